// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO read-side drainer.
// Data width comes from the global `DSIZE define, defaulting to 8 when it is not set.
`ifndef DSIZE
`define DSIZE 8
`endif

package fifo_pkg;
  localparam int RD_BUF_DEPTH = 2;
  localparam int DATA_W       = `DSIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drainer_state_t;
endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry circular buffer between the FIFO pop and the downstream stream.
// The head word is kept in its own register so it holds its last value while the buffer is empty.
module rd_skid_buf #(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DSIZE-1:0] wdata,
  output logic [1:0]       occ,
  output logic [DSIZE-1:0] head
);
  logic [DSIZE-1:0] r_mem [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_occ;
  logic [DSIZE-1:0] r_head_data;
  logic [1:0]       w_occ_nxt;
  logic [DSIZE-1:0] w_head_data_nxt;

  // The next head word is either the other stored entry, or the word arriving in this cycle.
  always_comb begin
    w_occ_nxt       = r_occ;
    w_head_data_nxt = r_head_data;
    case ({push, pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
    if (pop) begin
      if (r_occ == 2'd2)
        w_head_data_nxt = r_mem[~r_head];
      else if (push)
        w_head_data_nxt = wdata;
    end else if (r_occ == 2'd0 && push) begin
      w_head_data_nxt = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_occ       <= 2'd0;
      r_head_data <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= wdata;
        r_tail        <= ~r_tail;
      end
      if (pop)
        r_head <= ~r_head;
      r_occ       <= w_occ_nxt;
      r_head_data <= w_head_data_nxt;
    end
  end

  assign occ  = r_occ;
  assign head = r_head_data;
endmodule

// File: rtl/fifo_rd_drainer.sv
// Read-domain consumer: pops a first-word-fall-through FIFO into a 2-entry buffer and
// streams it out. Stream handshake: a word transfers on a posedge where m_valid && m_ready;
// m_valid does not depend on m_ready, and m_data is held while m_valid && !m_ready.
module fifo_rd_drainer
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DATA_W,
  parameter int CNT_W     = 16,
  parameter int BUF_DEPTH = RD_BUF_DEPTH
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count,
  output drainer_state_t   dbg_state
);
  generate
    if (BUF_DEPTH != RD_BUF_DEPTH) begin : g_bad_depth
      $error("fifo_rd_drainer: BUF_DEPTH must be 2");
    end
  endgenerate

  drainer_state_t   r_state;
  drainer_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_rd_count;
  logic [1:0]       w_occ;
  logic [DSIZE-1:0] w_head;
  logic             w_valid;
  logic             w_pop;
  logic             w_rinc;
  logic             w_empty_nxt;

  // Pop decision uses only registered state and rempty, never m_ready.
  assign w_rinc  = rrst_n && (r_state == RUN) && !rempty && (w_occ < 2'd2);
  assign w_valid = (w_occ != 2'd0);
  assign w_pop   = w_valid && m_ready;

  // Buffer is empty after this edge: nothing held and nothing arriving, or the last word leaving.
  assign w_empty_nxt = !w_rinc && ((w_occ == 2'd0) || (w_occ == 2'd1 && w_pop));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = w_empty_nxt ? IDLE : DRAIN;
      DRAIN: begin
        if (en)               w_state_nxt = RUN;
        else if (w_empty_nxt) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_state    <= IDLE;
      r_rd_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rinc)
        r_rd_count <= r_rd_count + 1'b1;
    end
  end

  rd_skid_buf #(
    .DSIZE(DSIZE)
  ) u_buf (
    .clk   (rclk),
    .rst_n (rrst_n),
    .push  (w_rinc),
    .pop   (w_pop),
    .wdata (rdata),
    .occ   (w_occ),
    .head  (w_head)
  );

  assign rinc      = w_rinc;
  assign m_valid   = w_valid;
  assign m_data    = w_head;
  assign busy      = (r_state != IDLE);
  assign rd_count  = r_rd_count;
  assign dbg_state = r_state;
endmodule

// File: doc/fifo_rd_drainer.md
Name: fifo_rd_drainer

Overview:
- Read-side consumer for the asynchronous FIFO. Runs entirely in the read clock domain.
- Pops words from the FIFO read port (rinc/rempty/rdata) and buffers them in a 2-entry output buffer.
- Presents buffered words downstream on a valid/ready stream.
- Counterpart to the write-side producer; used as the FIFO's real sink in the system and as the reference read agent in integration benches.

Parameters:
- DSIZE, `DSIZE (global define), data word width; must match the FIFO.
- CNT_W, 16, width of the words-read statistics counter.
- BUF_DEPTH, 2, output buffer entries; fixed at 2, any other value is illegal.

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rrst_n  in  1  reset, synchronous, active-low.
- en  in  1  enable draining; level-sensitive.
- rempty  in  1  FIFO empty flag (rclk domain).
- rdata  in  DSIZE  FIFO head word; valid whenever rempty=0 (first-word-fall-through).
- rinc  out  1  FIFO pop strobe; pops rdata at the posedge where rinc=1.
- m_valid  out  1  downstream word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DSIZE  downstream word (buffer head).
- busy  out  1  state != IDLE.
- rd_count  out  CNT_W  total words popped from the FIFO since reset.

Behaviour:
- Reset (rrst_n=0 at posedge):
  - state=IDLE, occupancy=0, head/tail pointers=0.
  - m_valid=0, m_data=0, rd_count=0, busy=0.
  - rinc=0 while rrst_n=0.
- Reset mid-operation discards buffered words. Words already popped are lost; no re-read.
- FIFO pop rule: rinc = (state==RUN) && !rempty && (occ < 2).
  - Combinational from rempty and registered state only. No path from m_ready to rinc.
  - rinc is never 1 while rempty=1; this is a hard requirement.
- Push: at a posedge with rinc=1, rdata is written to the tail and occ increments.
- Pop: at a posedge with m_valid && m_ready, the head advances and occ decrements.
- Simultaneous push and pop:
  - occ is unchanged.
  - At occ=1 the new word becomes head the next cycle.
  - This gives sustained throughput of 1 word/cycle with zero bubbles when the FIFO is non-empty and m_ready=1.
- Full and empty buffer:
  - occ=2 means no push that cycle, even if m_ready=1 (one bubble accepted).
  - occ=0 means m_valid=0.
- Output:
  - m_valid = (occ != 0), registered-derived.
  - m_data = head entry; held stable while m_valid && !m_ready.
  - m_data keeps its last value when m_valid=0. Not cleared except by reset.
- rd_count increments by 1 on every posedge with rinc=1. Wraps from 2^CNT_W-1 to 0; no saturation.
- FSM:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 and occ=0 -> IDLE; en=0 and occ!=0 -> DRAIN.
  - DRAIN: no new pops (rinc=0); buffered words are still delivered. en=1 -> RUN. occ reaching 0 (pop leaving empty) with en=0 -> IDLE.
  - en change takes effect on rinc in the cycle after the edge (state is registered).
- busy=1 in RUN and DRAIN.
- X on rdata while rempty=1 must not propagate into the buffer.

Decomposition:
- Shared package fifo_pkg:
  - typedef enum drainer_state_t {IDLE, RUN, DRAIN}.
  - localparam RD_BUF_DEPTH=2.
  - Data width taken from `DSIZE.
- Sub-module rd_skid_buf:
  - 2-entry circular buffer with push/pop/occ/head outputs, parameterised by DSIZE.
  - fifo_rd_drainer holds the FSM, the rinc logic and rd_count, and instantiates rd_skid_buf.

Test Plan:
- Streaming:
  - Stimulus: reset 3 cycles, en=1, FIFO preloaded with 0x11..0x18, m_ready=1.
  - Response: rinc high 8 consecutive cycles; m_data=0x11..0x18 in order, one per cycle; rd_count=8; no rinc once rempty=1.
- Backpressure:
  - Stimulus: FIFO holds 0xA0..0xA5, m_ready=0.
  - Response: exactly 2 pops (occ=2, rinc=0 afterwards); m_data=0xA0 held stable.
  - Then raise m_ready: 0xA0..0xA5 delivered in order; rd_count=6.
- Empty FIFO:
  - Stimulus: en=1, rempty=1, rdata=X for 20 cycles.
  - Response: rinc=0 and m_valid=0 throughout; rd_count=0.
- Disable and re-enable:
  - Stimulus: drop en with occ=2.
  - Response: state DRAIN, rinc=0, both words delivered, then IDLE with busy=0 one cycle after the last pop.
  - Re-raising en during DRAIN returns to RUN and pops resume the next cycle.
- Reset mid-stream:
  - Stimulus: assert rrst_n=0 while occ=2, m_valid=1.
  - Response: at the next posedge m_valid=0, rd_count=0, rinc=0; after release the next FIFO word is the first delivered.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 pops.
  - Response: rd_count reads 15 after 15 pops, 0 after 16, 1 after 17.
